// File: rtl/sram_resp_pkg.sv
// ---------------------------------------------------------------------------
// sram_resp_pkg
// Shared types and constants for the off-chip SRAM responder model:
//   - state_t : responder state (IDLE / READ / WRITE)
//   - ADDR_W_DEF / DATA_W_DEF : default bus widths (17-bit address, 64-bit data)
//   - CNT_W / CNT_SAT : width and saturate value of the read/write counters
//   - sat_inc() : saturating increment used by both counters
// ---------------------------------------------------------------------------
package sram_resp_pkg;

  localparam int unsigned ADDR_W_DEF = 17;
  localparam int unsigned DATA_W_DEF = 64;

  localparam int unsigned      CNT_W   = 3;
  localparam logic [CNT_W-1:0] CNT_SAT = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE
  } state_t;

  // Increment v by one but never beyond lim.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic [CNT_W-1:0] lim);
    return (v >= lim) ? lim : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/sram_resp_mem.sv
// ---------------------------------------------------------------------------
// sram_resp_mem
// DEPTH x DATA_W storage array for the SRAM responder. One synchronous write
// port and one registered read port sharing a single word index.
// Ports:
//   clk      in   clock
//   rst      in   asynchronous active-high reset (clears the read register only)
//   i_we     in   write strobe, writes i_wdata to word i_addr on the rising edge
//   i_addr   in   word index (IDX_W bits)
//   i_wdata  in   write data
//   o_rdata  out  registered read data of word i_addr (previous-edge contents)
// ---------------------------------------------------------------------------
module sram_resp_mem #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 131072,
  parameter int IDX_W  = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // NOTE: the array has no reset; only the small read register is reset, so
  // the array can map onto block RAM and a reset never disturbs its contents.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_rdata <= '0;
    end else begin
      o_rdata <= r_mem[i_addr];
    end
  end

endmodule

// File: rtl/sram_responder.sv
// ---------------------------------------------------------------------------
// sram_responder
// Cycle-accurate model of the off-chip SRAM seen by the MEM-stage SRAM
// controller. Answers multi-cycle reads (data driven after READ_LAT edges of
// a stable address) and writes (committed when sram_w_en returns high after
// being held low for at least WRITE_MIN edges).
// Ports:
//   clk           in     clock, all state on the rising edge
//   rst           in     asynchronous active-high reset
//   sram_address  in     word address (upper bits above log2(DEPTH) alias)
//   sram_w_en     in     write enable, active low
//   sram_dq       inout  data bus, driven only while read data is valid
//   resp_busy     out    high while read data is not valid or a write is open
//   viol          out    sticky protocol-violation flag
// Build option: define SRAM_RESP_CHECK_EN to enable the protocol checker
// (short write pulse / address change during a write set viol). Without it
// viol is tied low and no checker logic exists.
// ---------------------------------------------------------------------------
module sram_responder
  import sram_resp_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int DEPTH     = 131072,
  parameter int READ_LAT  = 2,
  parameter int WRITE_MIN = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] sram_address,
  input  logic              sram_w_en,
  inout  wire  [DATA_W-1:0] sram_dq,
  output logic              resp_busy,
  output logic              viol
);

  localparam int               IDX_W    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] RD_LAT_C = CNT_W'(READ_LAT);
  localparam logic [CNT_W-1:0] WR_MIN_C = CNT_W'(WRITE_MIN);

  state_t            r_state;
  logic [ADDR_W-1:0] r_lat_addr;
  logic [CNT_W-1:0]  r_rd_cnt;
  logic [CNT_W-1:0]  r_wr_cnt;
  logic [DATA_W-1:0] r_wr_data;

  logic              w_drv;
  logic              w_commit;
  logic [DATA_W-1:0] w_dq_out;

  // Commit happens on the edge that samples sram_w_en high again.
  assign w_commit = (r_state == ST_WRITE) && sram_w_en && (r_wr_cnt >= WR_MIN_C);

  sram_resp_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_commit),
    .i_addr  (r_lat_addr[IDX_W-1:0]),
    .i_wdata (r_wr_data),
    .o_rdata (w_dq_out)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees the pre-edge values of the others, whatever the statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_lat_addr <= '0;
      r_rd_cnt   <= '0;
      r_wr_cnt   <= '0;
      r_wr_data  <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_READ: begin
          if (!sram_w_en) begin
            // Write entry wins over a simultaneous address change.
            r_state    <= ST_WRITE;
            r_lat_addr <= sram_address;
            r_wr_cnt   <= CNT_W'(1);
            r_wr_data  <= sram_dq;
          end else if ((r_state == ST_IDLE) || (sram_address != r_lat_addr)) begin
            r_state    <= ST_READ;
            r_lat_addr <= sram_address;
            r_rd_cnt   <= '0;
          end else begin
            r_rd_cnt <= sat_inc(r_rd_cnt, RD_LAT_C);
          end
        end
        ST_WRITE: begin
          if (!sram_w_en) begin
            r_wr_data <= sram_dq;
            if (sram_address != r_lat_addr) begin
              r_lat_addr <= sram_address;
              r_wr_cnt   <= CNT_W'(1);
            end else begin
              r_wr_cnt <= sat_inc(r_wr_cnt, CNT_SAT);
            end
          end else begin
            r_state    <= ST_READ;
            r_lat_addr <= sram_address;
            r_rd_cnt   <= '0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Combinational on sram_w_en so the bus is released in the very cycle the
  // controller starts a write: no contention window.
  assign w_drv     = (r_state == ST_READ) && (r_rd_cnt == RD_LAT_C) && sram_w_en;
  assign sram_dq   = w_drv ? w_dq_out : {DATA_W{1'bz}};
  assign resp_busy = !w_drv;

`ifdef SRAM_RESP_CHECK_EN
  logic r_viol;
  logic w_short_wr;
  logic w_addr_chg;

  assign w_short_wr = (r_state == ST_WRITE) && sram_w_en && (r_wr_cnt < WR_MIN_C);
  assign w_addr_chg = (r_state == ST_WRITE) && !sram_w_en && (sram_address != r_lat_addr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_viol <= 1'b0;
    end else if (w_short_wr || w_addr_chg) begin
      r_viol <= 1'b1;
`ifndef SYNTHESIS
      if (w_short_wr) begin
        $display("sram_responder warning: short write pulse at address %h", r_lat_addr);
      end else begin
        $display("sram_responder warning: address change during write, %h -> %h",
                 r_lat_addr, sram_address);
      end
`endif
    end
  end

  assign viol = r_viol;
`else
  assign viol = 1'b0;
`endif

endmodule

// File: tb/tb_sram_responder.sv
// ---------------------------------------------------------------------------
// tb_sram_responder
// Self-checking bench for sram_responder (DEPTH=1024 so aliasing is visible).
// A behavioural model (word array plus "edges the address has been held" /
// "edges w_en has been low") predicts busy, bus data and viol; a negedge
// process compares them every cycle. Directed sequences pin literal values,
// then randomized reads and writes run against the model.
// ---------------------------------------------------------------------------
module tb_sram_responder;

  localparam int ADDR_W    = 17;
  localparam int DATA_W    = 64;
  localparam int DEPTH     = 1024;
  localparam int READ_LAT  = 2;
  localparam int WRITE_MIN = 2;

`ifdef SRAM_RESP_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [ADDR_W-1:0] tb_addr = '0;
  logic              tb_wen = 1'b1;
  logic [DATA_W-1:0] tb_dq = '0;
  logic              tb_dq_oe = 1'b0;
  wire  [DATA_W-1:0] sram_dq;
  logic              resp_busy;
  logic              viol;

  int n_checks = 0;
  int n_errs   = 0;

  always #5 clk = ~clk;

  assign sram_dq = tb_dq_oe ? tb_dq : {DATA_W{1'bz}};

  sram_responder #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .READ_LAT  (READ_LAT),
    .WRITE_MIN (WRITE_MIN)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sram_address (tb_addr),
    .sram_w_en    (tb_wen),
    .sram_dq      (sram_dq),
    .resp_busy    (resp_busy),
    .viol         (viol)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit bus_released();
    return $isunknown(sram_dq) || (sram_dq == '0);
  endfunction

  // ---------------- behavioural model ----------------
  typedef enum {M_IDLE, M_READ, M_WRITE} mode_t;
  mode_t             m_mode  = M_IDLE;
  logic [ADDR_W-1:0] m_addr  = '0;
  int                m_held  = 0;   // edges the read address has been stable
  int                m_pulse = 0;   // edges w_en has been low on this address
  logic [DATA_W-1:0] m_wdata = '0;
  bit                m_viol  = 1'b0;
  logic [DATA_W-1:0] m_mem   [DEPTH];
  bit                m_known [DEPTH];

  function automatic int widx(input logic [ADDR_W-1:0] a);
    return int'(a % DEPTH);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode  <= M_IDLE;
      m_addr  <= '0;
      m_held  <= 0;
      m_pulse <= 0;
      m_viol  <= 1'b0;
    end else if (m_mode == M_WRITE) begin
      if (!tb_wen) begin
        m_wdata <= tb_dq;
        if (tb_addr != m_addr) begin
          m_addr  <= tb_addr;
          m_pulse <= 1;
          if (CHK_EN) m_viol <= 1'b1;
        end else begin
          m_pulse <= m_pulse + 1;
        end
      end else begin
        if (m_pulse >= WRITE_MIN) begin
          m_mem[widx(m_addr)]   <= m_wdata;
          m_known[widx(m_addr)] <= 1'b1;
        end else if (CHK_EN) begin
          m_viol <= 1'b1;
        end
        m_mode <= M_READ;
        m_addr <= tb_addr;
        m_held <= 0;
      end
    end else begin
      if (!tb_wen) begin
        m_mode  <= M_WRITE;
        m_addr  <= tb_addr;
        m_pulse <= 1;
        m_wdata <= tb_dq;
      end else if (m_mode == M_IDLE || tb_addr != m_addr) begin
        m_mode <= M_READ;
        m_addr <= tb_addr;
        m_held <= 0;
      end else begin
        m_held <= m_held + 1;
      end
    end
  end

  // ---------------- per-cycle comparison ----------------
  always @(negedge clk) begin : cmp
    bit exp_drv;
    exp_drv = (m_mode == M_READ) && (m_held >= READ_LAT) && tb_wen;
    check("busy", 64'(resp_busy), 64'(!exp_drv));
    check("viol", 64'(viol), 64'(m_viol));
    if (exp_drv && m_known[widx(m_addr)])
      check("rd_data", sram_dq, m_mem[widx(m_addr)]);
    if (!exp_drv && tb_wen)
      check("bus_release", 64'(bus_released()), 64'd1);
  end

  // ---------------- stimulus helpers ----------------
  task automatic apply(input logic [ADDR_W-1:0] a, input logic w, input logic [DATA_W-1:0] d);
    tb_addr  = a;
    tb_wen   = w;
    tb_dq    = w ? '0 : d;
    tb_dq_oe = !w;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic [ADDR_W-1:0] a, input logic w, input logic [DATA_W-1:0] d);
    apply(a, w, d);
    tick();
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input int n);
    repeat (n) cyc(a, 1'b0, d);
    cyc(a, 1'b1, '0);
  endtask

  initial begin
    logic [ADDR_W-1:0] a;
    // Reset with w_en high
    apply('0, 1'b1, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(resp_busy), 64'd1);
    check("rst_viol", 64'(viol), 64'd0);
    check("rst_bus_z", 64'(bus_released()), 64'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();                               // IDLE -> READ, held 0
    tick();                               // held 1
    @(negedge clk);
    check("post_rst_lat1", 64'(resp_busy), 64'd1);
    tick();                               // held 2
    @(negedge clk);
    check("post_rst_read", 64'(resp_busy), 64'd0);
    tick();

    // Give the words used below known contents
    for (int k = 0; k < 16; k++) wr(ADDR_W'(k), '0, 2);

    // Write 5 with a 5-cycle pulse, then read it back
    wr(17'd5, 64'h0000_0000_DEAD_BEEF, 5);
    apply(17'd5, 1'b1, '0);
    @(negedge clk);
    check("wr5_lat0", 64'(resp_busy), 64'd1);
    tick();
    @(negedge clk);
    check("wr5_lat1", 64'(resp_busy), 64'd1);
    tick();
    @(negedge clk);
    check("wr5_busy", 64'(resp_busy), 64'd0);
    check("wr5_data", sram_dq, 64'h0000_0000_DEAD_BEEF);
    tick();

    // Short write at 9: no commit
    wr(17'd9, 64'h1234, 1);
    apply(17'd9, 1'b1, '0);
    tick();
    tick();
    @(negedge clk);
    check("short_busy", 64'(resp_busy), 64'd0);
    check("short_data", sram_dq, 64'd0);
    check("short_viol", 64'(viol), 64'(CHK_EN));
    tick();

    // Address change during a read
    wr(17'd3, 64'h3333, 2);
    wr(17'd4, 64'h4444, 2);
    apply(17'd3, 1'b1, '0);
    repeat (3) tick();
    @(negedge clk);
    check("rd3_data", sram_dq, 64'h3333);
    tick();
    apply(17'd4, 1'b1, '0);
    @(negedge clk);
    check("chg_hold_busy", 64'(resp_busy), 64'd0);
    check("chg_hold_data", sram_dq, 64'h3333);
    tick();
    @(negedge clk);
    check("chg_z0", 64'(resp_busy), 64'd1);
    tick();
    @(negedge clk);
    check("chg_z1", 64'(resp_busy), 64'd1);
    tick();
    @(negedge clk);
    check("rd4_data", sram_dq, 64'h4444);
    tick();
    // w_en falls while driving: bus released in the same cycle
    apply(17'd4, 1'b0, 64'h0004_0004);
    @(negedge clk);
    check("wen_fall_busy", 64'(resp_busy), 64'd1);
    tick();
    wr(17'd4, 64'h0004_0004, 1);

    // Reset in the middle of a write to 7
    rst = 1'b0;
    repeat (3) cyc(17'd7, 1'b0, 64'hAA);
    apply(17'd7, 1'b1, '0);
    rst = 1'b1;
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_wr_busy", 64'(resp_busy), 64'd0);
    check("rst_wr_data", sram_dq, 64'd0);
    check("rst_wr_viol", 64'(viol), 64'd0);
    tick();

    // Aliasing: 1024 and 0 are the same word
    wr(17'd1024, 64'h55, 2);
    apply(17'd0, 1'b1, '0);
    repeat (3) tick();
    @(negedge clk);
    check("alias_data", sram_dq, 64'h55);
    tick();

    // Randomized traffic over 16 words and their aliases
    for (int t = 0; t < 200; t++) begin
      a = {7'($urandom), 10'($urandom_range(0, 15))};
      case ($urandom_range(0, 3))
        0, 1: repeat ($urandom_range(1, 5)) cyc(a, 1'b1, '0);
        2: begin
          repeat ($urandom_range(1, 6)) begin
            if ($urandom_range(0, 7) == 0) a = {7'($urandom), 10'($urandom_range(0, 15))};
            cyc(a, 1'b0, {$urandom, $urandom});
          end
          cyc({7'($urandom), 10'($urandom_range(0, 15))}, 1'b1, '0);
        end
        default: repeat (READ_LAT + 2) cyc(a, 1'b1, '0);
      endcase
    end
    cyc('0, 1'b1, '0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
